// File: rtl/ram_matmul_pkg.sv
// Shared types and elaboration helpers for the RAM-fed matrix multiply engine.
package ram_matmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    LAST  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Wide enough for N products of two full-scale DW-bit operands.
  function automatic int result_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic bit addr_fits(input int n, input int aw);
    return (2 ** aw) >= (n * n);
  endfunction

endpackage

// File: rtl/ram_mac_dp.sv
// Unsigned multiply-accumulate datapath: combinational product of the two RAM
// read ports, zero-extended into the single accumulator register.
module ram_mac_dp
  import ram_matmul_pkg::*;
#(
  parameter int DW = 4,
  parameter int RW = result_width(4, 4)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a_q,
  input  logic [DW-1:0] b_q,
  output logic [RW-1:0] acc
);

  logic [2*DW-1:0] prod_s;
  logic [RW-1:0]   acc_r;

  assign prod_s = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};

  // Accumulator: clear wins over enable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_r <= {RW{1'b0}};
    end else if (clr) begin
      acc_r <= {RW{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + RW'(prod_s);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/ram_matmul_engine.sv
// Walks operand RAMs A and B (row-major N x N) and writes C = A x B to a result
// port, one element every N+2 cycles.
module ram_matmul_engine
  import ram_matmul_pkg::*;
#(
  parameter int  N  = 4,
  parameter int  DW = 4,
  parameter int  AW = 4,
  localparam int RW = result_width(N, DW)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  output logic [AW-1:0] a_addr,
  output logic          a_we,
  input  logic [DW-1:0] a_q,
  output logic [AW-1:0] b_addr,
  output logic          b_we,
  input  logic [DW-1:0] b_q,
  output logic [AW-1:0] res_addr,
  output logic [RW-1:0] res_data,
  output logic          res_we,
  output logic          busy,
  output logic          done
);

  if (!addr_fits(N, AW)) begin : g_aw_check
    $error("ram_matmul_engine: AW too small to address N*N elements");
  end

  localparam logic [AW-1:0] ZERO     = {AW{1'b0}};
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  function automatic logic [AW-1:0] flat(input logic [AW-1:0] row, input logic [AW-1:0] col);
    int tmp;
    tmp = int'(row) * N + int'(col);
    return tmp[AW-1:0];
  endfunction

  state_t        state_r, state_s;
  logic [AW-1:0] i_r, j_r, k_r, i_s, j_s, k_s;
  logic [AW-1:0] a_addr_r, b_addr_r, res_addr_r;
  logic          res_we_r, busy_r, done_r;
  logic          acc_clr_s, acc_en_s;
  logic [RW-1:0] acc_s;

  // Next-state and i/j/k counter sequencing.
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    k_s     = k_r;
    case (state_r)
      IDLE: begin
        i_s = ZERO;
        j_s = ZERO;
        k_s = ZERO;
        if (start) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (k_r == LAST_IDX) begin
          state_s = LAST;
        end else begin
          k_s = k_r + ONE;
        end
      end
      LAST: state_s = WRITE;
      WRITE: begin
        k_s = ZERO;
        if (j_r == LAST_IDX) begin
          j_s = ZERO;
          if (i_r == LAST_IDX) begin
            i_s     = ZERO;
            state_s = DONE;
          end else begin
            i_s     = i_r + ONE;
            state_s = ISSUE;
          end
        end else begin
          j_s     = j_r + ONE;
          state_s = ISSUE;
        end
      end
      DONE: state_s = IDLE;
      default: begin
        state_s = IDLE;
        i_s     = ZERO;
        j_s     = ZERO;
        k_s     = ZERO;
      end
    endcase
  end

  // Read data lags the address by one edge, so the product seen in ISSUE(k) belongs to k-1.
  assign acc_en_s  = ((state_r == ISSUE) && (k_r != ZERO)) || (state_r == LAST);
  assign acc_clr_s = (state_r == IDLE) || (state_r == WRITE);

  // State, counters and registered outputs, all loaded from next-state values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      i_r        <= ZERO;
      j_r        <= ZERO;
      k_r        <= ZERO;
      a_addr_r   <= ZERO;
      b_addr_r   <= ZERO;
      res_addr_r <= ZERO;
      res_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      i_r        <= i_s;
      j_r        <= j_s;
      k_r        <= k_s;
      a_addr_r   <= flat(i_s, k_s);
      b_addr_r   <= flat(k_s, j_s);
      res_addr_r <= (state_s == WRITE) ? flat(i_s, j_s) : ZERO;
      res_we_r   <= (state_s == WRITE);
      busy_r     <= (state_s == ISSUE) || (state_s == LAST) || (state_s == WRITE);
      done_r     <= (state_s == DONE);
    end
  end

  ram_mac_dp #(
    .DW (DW),
    .RW (RW)
  ) u_mac (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (acc_clr_s),
    .en      (acc_en_s),
    .a_q     (a_q),
    .b_q     (b_q),
    .acc     (acc_s)
  );

  assign a_addr   = a_addr_r;
  assign b_addr   = b_addr_r;
  assign a_we     = 1'b0;
  assign b_we     = 1'b0;
  assign res_addr = res_addr_r;
  assign res_data = acc_s;
  assign res_we   = res_we_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
